// File: rtl/sram_1r1w_be_ctrl.sv
// Front-end for a 1R1W byte-enable SRAM: zero-fills the array after reset,
// then serves one writer and two round-robin read clients with write-to-read forwarding.
module sram_1r1w_be_ctrl #(
  parameter int ADDR_SZ       = 9,
  parameter int DATA_SZ_BYTES = 8,
  parameter int MEM_SZ        = 512
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       init_done,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [ADDR_SZ-1:0]         wr_addr,
  input  logic [DATA_SZ_BYTES-1:0]   wr_bytes,
  input  logic [DATA_SZ_BYTES*8-1:0] wr_data,
  input  logic [1:0]                 rd_req_valid,
  output logic [1:0]                 rd_req_ready,
  input  logic [2*ADDR_SZ-1:0]       rd_req_addr,
  output logic [1:0]                 rd_resp_valid,
  input  logic [1:0]                 rd_resp_ready,
  output logic [DATA_SZ_BYTES*8-1:0] rd_resp_data,
  output logic                       sram_write_en,
  output logic [DATA_SZ_BYTES-1:0]   sram_write_bytes,
  output logic [ADDR_SZ-1:0]         sram_write_addr,
  output logic [DATA_SZ_BYTES*8-1:0] sram_write_data,
  output logic                       sram_read_en,
  output logic [ADDR_SZ-1:0]         sram_read_addr,
  input  logic [DATA_SZ_BYTES*8-1:0] sram_read_data
);
  localparam int D = DATA_SZ_BYTES * 8;
  localparam logic [ADDR_SZ-1:0] LAST_ADDR = ADDR_SZ'(MEM_SZ - 1);

  typedef enum logic {INIT, RUN} state_e;

  state_e                   state_q, state_d;
  logic [ADDR_SZ-1:0]       init_cnt_q, init_cnt_d;
  logic                     init_done_q, init_done_d;
  logic                     rr_ptr_q, rr_ptr_d;
  logic [1:0]               resp_valid_q, resp_valid_d;
  logic [DATA_SZ_BYTES-1:0] fwd_mask_q, fwd_mask_d;
  logic [D-1:0]             fwd_data_q, fwd_data_d;

  logic [1:0]         grant;
  logic               rd_free;
  logic [ADDR_SZ-1:0] rd_addr;

  always_comb begin
    state_d          = state_q;
    init_cnt_d       = init_cnt_q;
    init_done_d      = init_done_q;
    rr_ptr_d         = rr_ptr_q;
    resp_valid_d     = resp_valid_q;
    fwd_mask_d       = fwd_mask_q;
    fwd_data_d       = fwd_data_q;
    grant            = 2'b00;
    wr_ready         = 1'b0;
    sram_write_en    = 1'b0;
    sram_write_bytes = '0;
    sram_write_addr  = '0;
    sram_write_data  = '0;
    sram_read_en     = 1'b0;
    sram_read_addr   = '0;

    // A new read may be accepted in the same cycle the held response drains.
    rd_free = (resp_valid_q == 2'b00) || ((resp_valid_q & rd_resp_ready) != 2'b00);

    case (state_q)
      INIT: begin
        sram_write_en    = 1'b1;
        sram_write_bytes = '1;
        sram_write_addr  = init_cnt_q;
        init_cnt_d       = init_cnt_q + 1'b1;
        if (init_cnt_q == LAST_ADDR) begin
          state_d     = RUN;
          init_done_d = 1'b1;
        end
      end
      RUN: begin
        wr_ready         = 1'b1;
        sram_write_en    = wr_valid;
        sram_write_bytes = wr_bytes;
        sram_write_addr  = wr_addr;
        sram_write_data  = wr_data;
        resp_valid_d     = resp_valid_q & ~rd_resp_ready;
        if (rd_free) begin
          if (rd_req_valid == 2'b11) grant = rr_ptr_q ? 2'b10 : 2'b01;
          else                       grant = rd_req_valid;
        end
      end
      default: state_d = INIT;
    endcase

    rd_addr = grant[1] ? rd_req_addr[ADDR_SZ +: ADDR_SZ] : rd_req_addr[0 +: ADDR_SZ];

    if (grant != 2'b00) begin
      sram_read_en   = 1'b1;
      sram_read_addr = rd_addr;
      rr_ptr_d       = grant[0];
      resp_valid_d   = grant;
      // SRAM returns pre-write data on a same-address collision; patch those bytes.
      fwd_mask_d     = (wr_valid && wr_addr == rd_addr) ? wr_bytes : '0;
      fwd_data_d     = wr_data;
    end

    if (reset) begin
      wr_ready      = 1'b0;
      sram_write_en = 1'b0;
      sram_read_en  = 1'b0;
      grant         = 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= INIT;
      init_cnt_q   <= '0;
      init_done_q  <= 1'b0;
      rr_ptr_q     <= 1'b0;
      resp_valid_q <= 2'b00;
      fwd_mask_q   <= '0;
      fwd_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      init_cnt_q   <= init_cnt_d;
      init_done_q  <= init_done_d;
      rr_ptr_q     <= rr_ptr_d;
      resp_valid_q <= resp_valid_d;
      fwd_mask_q   <= fwd_mask_d;
      fwd_data_q   <= fwd_data_d;
    end
  end

  always_comb begin
    rd_resp_data = sram_read_data;
    for (int b = 0; b < DATA_SZ_BYTES; b++)
      if (fwd_mask_q[b]) rd_resp_data[b*8 +: 8] = fwd_data_q[b*8 +: 8];
  end

  assign init_done     = init_done_q;
  assign rd_req_ready  = grant;
  assign rd_resp_valid = resp_valid_q;
endmodule

// File: tb/tb_sram_1r1w_be_ctrl.sv
// Random + directed bench for sram_1r1w_be_ctrl against a word-array model of
// the memory contents and the pending response of each client.
module tb_sram_1r1w_be_ctrl;
  localparam int ADDR_SZ = 9;
  localparam int NB      = 8;
  localparam int MEM_SZ  = 512;
  localparam int D       = NB * 8;

  logic               clk = 1'b0;
  logic               reset;
  logic               init_done;
  logic               wr_valid, wr_ready;
  logic [ADDR_SZ-1:0] wr_addr;
  logic [NB-1:0]      wr_bytes;
  logic [D-1:0]       wr_data;
  logic [1:0]         rd_req_valid, rd_req_ready;
  logic [2*ADDR_SZ-1:0] rd_req_addr;
  logic [1:0]         rd_resp_valid, rd_resp_ready;
  logic [D-1:0]       rd_resp_data;
  logic               sram_write_en, sram_read_en;
  logic [NB-1:0]      sram_write_bytes;
  logic [ADDR_SZ-1:0] sram_write_addr, sram_read_addr;
  logic [D-1:0]       sram_write_data, sram_read_data;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  sram_1r1w_be_ctrl #(.ADDR_SZ(ADDR_SZ), .DATA_SZ_BYTES(NB), .MEM_SZ(MEM_SZ)) dut (
    .clk(clk), .reset(reset), .init_done(init_done),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_bytes(wr_bytes), .wr_data(wr_data),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_addr(rd_req_addr),
    .rd_resp_valid(rd_resp_valid), .rd_resp_ready(rd_resp_ready), .rd_resp_data(rd_resp_data),
    .sram_write_en(sram_write_en), .sram_write_bytes(sram_write_bytes),
    .sram_write_addr(sram_write_addr), .sram_write_data(sram_write_data),
    .sram_read_en(sram_read_en), .sram_read_addr(sram_read_addr),
    .sram_read_data(sram_read_data)
  );

  always #5 clk = ~clk;

  // SRAM: registered read, output held while read_en is low, read-before-write.
  logic [D-1:0] sram_mem [MEM_SZ];
  logic [D-1:0] sram_rd_q;
  assign sram_read_data = sram_rd_q;
  initial begin
    for (int i = 0; i < MEM_SZ; i++) sram_mem[i] <= {$urandom, $urandom};
    sram_rd_q <= {$urandom, $urandom};
  end
  always @(posedge clk) begin
    if (sram_read_en) sram_rd_q <= sram_mem[sram_read_addr];
    if (sram_write_en)
      for (int b = 0; b < NB; b++)
        if (sram_write_bytes[b]) sram_mem[sram_write_addr][b*8 +: 8] <= sram_write_data[b*8 +: 8];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: event not seen within cycle budget at %0t", name, $time);
  endtask

  // Behavioural model: memory contents, init progress, and the response each client is owed.
  logic [D-1:0] m_mem [MEM_SZ];
  int           m_cnt;
  bit           m_done, m_rr, m_pend, m_cli;
  logic [D-1:0] m_data;

  function automatic logic [1:0] m_grant();
    if (reset || !m_done) return 2'b00;
    if (m_pend && !rd_resp_ready[m_cli]) return 2'b00;
    if (rd_req_valid == 2'b11) return m_rr ? 2'b10 : 2'b01;
    return rd_req_valid;
  endfunction

  always @(posedge clk) begin : model
    logic [1:0] g;
    logic [ADDR_SZ-1:0] a;
    logic [D-1:0] v;
    g = m_grant();
    if (reset) begin
      m_cnt = 0; m_done = 0; m_rr = 0; m_pend = 0;
    end else if (!m_done) begin
      m_mem[m_cnt] = '0;
      if (m_cnt == MEM_SZ - 1) m_done = 1;
      m_cnt++;
    end else begin
      if (m_pend && rd_resp_ready[m_cli]) m_pend = 0;
      if (g != 2'b00) begin
        a = g[1] ? rd_req_addr[ADDR_SZ +: ADDR_SZ] : rd_req_addr[0 +: ADDR_SZ];
        v = m_mem[a];
        if (wr_valid && wr_addr == a)
          for (int b = 0; b < NB; b++) if (wr_bytes[b]) v[b*8 +: 8] = wr_data[b*8 +: 8];
        m_data = v; m_pend = 1; m_cli = g[1]; m_rr = !g[1];
      end
      if (wr_valid)
        for (int b = 0; b < NB; b++) if (wr_bytes[b]) m_mem[wr_addr][b*8 +: 8] = wr_data[b*8 +: 8];
    end
  end

  always @(negedge clk) begin : cmp
    logic [1:0] g;
    if (chk_en) begin
      g = m_grant();
      if (reset) begin
        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_rd_req_ready", rd_req_ready, 0);
        chk("rst_write_en", sram_write_en, 0);
        chk("rst_read_en", sram_read_en, 0);
      end else if (!m_done) begin
        chk("init_done_low", init_done, 0);
        chk("init_wr_ready", wr_ready, 0);
        chk("init_rd_req_ready", rd_req_ready, 0);
        chk("init_read_en", sram_read_en, 0);
        chk("init_write_en", sram_write_en, 1);
        chk("init_write_addr", sram_write_addr, m_cnt);
        chk("init_write_bytes", sram_write_bytes, {NB{1'b1}});
        chk("init_write_data", sram_write_data, 0);
      end else begin
        chk("run_init_done", init_done, 1);
        chk("run_wr_ready", wr_ready, 1);
        chk("run_write_en", sram_write_en, wr_valid);
        if (wr_valid) begin
          chk("run_write_addr", sram_write_addr, wr_addr);
          chk("run_write_bytes", sram_write_bytes, wr_bytes);
          chk("run_write_data", sram_write_data, wr_data);
        end
        chk("run_grant", rd_req_ready, g);
        chk("run_read_en", sram_read_en, g != 2'b00);
        if (g != 2'b00)
          chk("run_read_addr", sram_read_addr,
              g[1] ? rd_req_addr[ADDR_SZ +: ADDR_SZ] : rd_req_addr[0 +: ADDR_SZ]);
      end
      chk("resp_valid", rd_resp_valid, m_pend ? (m_cli ? 2'b10 : 2'b01) : 2'b00);
      if (m_pend) chk("resp_data", rd_resp_data, m_data);
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    wr_valid = 0; wr_addr = '0; wr_bytes = '0; wr_data = '0;
    rd_req_valid = 2'b00; rd_req_addr = '0; rd_resp_ready = 2'b11;
  endtask

  // Called right after reset release: expects writes to 0..MEM_SZ-1, then init_done.
  task automatic check_init_sweep();
    int n = 0;
    bit seen_last = 0;
    bit done = 0;
    for (int c = 0; c < MEM_SZ + 20 && !done; c++) begin
      @(negedge clk);
      if (init_done) begin
        chk("init_done_after_last_write", seen_last, 1);
        chk("init_write_count", n, MEM_SZ);
        done = 1;
      end else if (sram_write_en) begin
        chk("sweep_addr", sram_write_addr, n);
        chk("sweep_bytes", sram_write_bytes, 8'hFF);
        seen_last = (n == MEM_SZ - 1);
        n++;
      end
    end
    if (!done) fail_now("init_done_timeout");
  endtask

  initial begin
    bit found;
    reset = 1; idle();
    step(); chk_en = 1;
    step(); step();
    reset = 0;
    check_init_sweep();

    // Full write then read of address 5.
    step();
    wr_valid = 1; wr_addr = 5; wr_bytes = 8'hFF; wr_data = 64'h1122334455667788;
    step();
    wr_valid = 0; rd_req_valid = 2'b01; rd_req_addr[0 +: ADDR_SZ] = 5;
    @(negedge clk);
    chk("rd5_grant", rd_req_ready, 2'b01);
    chk("rd5_read_addr", sram_read_addr, 5);
    step();
    rd_req_valid = 2'b00;
    @(negedge clk);
    chk("rd5_resp_valid", rd_resp_valid, 2'b01);
    chk("rd5_resp_data", rd_resp_data, 64'h1122334455667788);

    // Same-cycle partial write and read of address 7.
    step();
    wr_valid = 1; wr_addr = 7; wr_bytes = 8'h0F; wr_data = {8{8'hAA}};
    rd_req_valid = 2'b10; rd_req_addr[ADDR_SZ +: ADDR_SZ] = 7;
    @(negedge clk);
    chk("fwd_grant", rd_req_ready, 2'b10);
    step();
    wr_valid = 0; rd_req_valid = 2'b00;
    @(negedge clk);
    chk("fwd_resp_valid", rd_resp_valid, 2'b10);
    chk("fwd_resp_data", rd_resp_data, 64'h00000000AAAAAAAA);

    // Both clients streaming: grants alternate starting with client 0.
    step();
    rd_req_valid = 2'b11;
    rd_req_addr[0 +: ADDR_SZ] = 5; rd_req_addr[ADDR_SZ +: ADDR_SZ] = 7;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rr_grant", rd_req_ready, (i % 2) ? 2'b10 : 2'b01);
      if (i > 0) chk("rr_resp_valid", rd_resp_valid, (i % 2) ? 2'b01 : 2'b10);
      step();
    end
    rd_req_valid = 2'b00;
    step(); step();

    // Client 0 response held; client 1 waits until it drains.
    rd_resp_ready = 2'b00; rd_req_valid = 2'b01;
    @(negedge clk);
    chk("hold_grant0", rd_req_ready, 2'b01);
    step();
    rd_req_valid = 2'b10;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_no_grant", rd_req_ready, 2'b00);
      chk("hold_no_read", sram_read_en, 0);
      chk("hold_resp_valid", rd_resp_valid, 2'b01);
      chk("hold_resp_data", rd_resp_data, 64'h1122334455667788);
      step();
    end
    rd_resp_ready = 2'b01;
    @(negedge clk);
    chk("hold_release_grant1", rd_req_ready, 2'b10);
    step();
    rd_req_valid = 2'b00; rd_resp_ready = 2'b11;
    @(negedge clk);
    chk("hold_resp1_valid", rd_resp_valid, 2'b10);
    chk("hold_resp1_data", rd_resp_data, 64'h00000000AAAAAAAA);

    // Random traffic on a small address window to force collisions.
    for (int i = 0; i < 3000; i++) begin
      step();
      wr_valid = $urandom_range(0, 1);
      wr_addr  = ADDR_SZ'($urandom_range(0, 15));
      wr_bytes = NB'($urandom);
      wr_data  = {$urandom, $urandom};
      rd_req_valid = 2'($urandom);
      rd_req_addr[0 +: ADDR_SZ]       = ADDR_SZ'($urandom_range(0, 15));
      rd_req_addr[ADDR_SZ +: ADDR_SZ] = ADDR_SZ'($urandom_range(0, 15));
      rd_resp_ready[0] = ($urandom_range(0, 3) != 0);
      rd_resp_ready[1] = ($urandom_range(0, 3) != 0);
    end
    step(); idle();
    step(); step();

    // Reset with a response pending: it must be discarded.
    rd_resp_ready = 2'b00; rd_req_valid = 2'b01; rd_req_addr[0 +: ADDR_SZ] = 3;
    step();
    rd_req_valid = 2'b00;
    @(negedge clk);
    chk("pend_before_reset", rd_resp_valid, 2'b01);
    step();
    reset = 1;
    step();
    reset = 0; rd_resp_ready = 2'b11;
    @(negedge clk);
    chk("reset_discard_resp", rd_resp_valid, 2'b00);

    // Reset again once init_cnt reaches 100; sweep must restart from 0.
    found = 0;
    for (int c = 0; c < MEM_SZ + 20 && !found; c++) begin
      if (sram_write_en && !init_done && sram_write_addr == 99) found = 1;
      else @(negedge clk);
    end
    if (!found) fail_now("init_cnt_99");
    step();
    chk("midinit_addr100", sram_write_addr, 100);
    reset = 1;
    step();
    reset = 0;
    check_init_sweep();
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
